// File: rtl/io_reg_bank.sv
// Bank of DEPTH IO registers with write/set/clear/toggle writes, a registered read port,
// sticky per-register change flags and an OR-reduced interrupt.
module io_reg_bank #(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      DEPTH     = 4,
    parameter int unsigned      AW        = $clog2(DEPTH),
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [1:0]               wr_mode,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [AW-1:0]            rd_addr,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic                     rd_err,
    output logic [DEPTH*WIDTH-1:0]   reg_out,
    output logic [DEPTH-1:0]         chg_flags,
    input  logic [DEPTH-1:0]         chg_clr,
    output logic                     irq
);

    localparam logic [1:0] MODE_WRITE  = 2'b00;
    localparam logic [1:0] MODE_SET    = 2'b01;
    localparam logic [1:0] MODE_CLEAR  = 2'b10;
    localparam logic [1:0] MODE_TOGGLE = 2'b11;

    logic [DEPTH-1:0][WIDTH-1:0] regs_q, regs_d;
    logic [DEPTH-1:0]            flags_q, flags_d;
    logic [WIDTH-1:0]            rd_data_q, rd_data_d;
    logic                        rd_valid_q, rd_valid_d;
    logic                        rd_err_q, rd_err_d;
    logic                        irq_q, irq_d;

    logic                        wr_hit_c;
    logic                        rd_in_range_c;
    logic [WIDTH-1:0]            wr_old_c;
    logic [WIDTH-1:0]            wr_new_c;

    // Next-state: write-mode update, change detection and read capture (read sees pre-write value)
    always_comb begin
        regs_d        = regs_q;
        flags_d       = flags_q & ~chg_clr;
        rd_data_d     = rd_data_q;
        rd_valid_d    = 1'b0;
        rd_err_d      = 1'b0;
        irq_d         = |flags_q;
        wr_old_c      = '0;
        wr_new_c      = '0;
        wr_hit_c      = wr_en && (32'(wr_addr) < DEPTH);
        rd_in_range_c = 32'(rd_addr) < DEPTH;

        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (wr_addr == AW'(i)) begin
                wr_old_c = regs_q[i];
            end
        end

        case (wr_mode)
            MODE_WRITE:  wr_new_c = wr_data;
            MODE_SET:    wr_new_c = wr_old_c | wr_data;
            MODE_CLEAR:  wr_new_c = wr_old_c & ~wr_data;
            MODE_TOGGLE: wr_new_c = wr_old_c ^ wr_data;
            default:     wr_new_c = wr_data;
        endcase

        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (wr_hit_c && (wr_addr == AW'(i))) begin
                regs_d[i] = wr_new_c;
                // A set in the same cycle as a clear request wins
                if (wr_new_c != wr_old_c) begin
                    flags_d[i] = 1'b1;
                end
            end
        end

        if (rd_en) begin
            rd_valid_d = 1'b1;
            rd_err_d   = !rd_in_range_c;
            rd_data_d  = '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (rd_in_range_c && (rd_addr == AW'(i))) begin
                    rd_data_d = regs_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q     <= {DEPTH{RESET_VAL}};
            flags_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            flags_q    <= flags_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
            irq_q      <= irq_d;
        end
    end

    assign reg_out   = regs_q;
    assign chg_flags = flags_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign rd_err    = rd_err_q;
    assign irq       = irq_q;

endmodule
